// File: rtl/ovl_pkg.sv
// Purpose : shared glyph constants (origins, colours, 8x8 bitmaps) and FSM state type.
// Latency : n/a (constants and a pure helper function only).
// Backpr. : n/a.
// Contents: OVL_* glyph indices, GLYPH_X0/Y0 origins, GLYPH_COLOR, GLYPH_BMP,
//           comp_state_e, glyph_row() bitmap row lookup.
package ovl_pkg;

    localparam int OVL_CNT = 4;
    localparam int PIX_W   = 16;

    localparam int OVL_HUNGRY = 0;
    localparam int OVL_SICK   = 1;
    localparam int OVL_SAD    = 2;
    localparam int OVL_TIRED  = 3;

    // Top-left corner of each glyph, indexed by the OVL_* constants.
    localparam int unsigned GLYPH_X0 [OVL_CNT] = '{76, 82, 88, 55};
    localparam int unsigned GLYPH_Y0 [OVL_CNT] = '{57, 53, 58, 44};

    localparam logic [PIX_W-1:0] GLYPH_COLOR [OVL_CNT] =
        '{16'h0000, 16'h4dac, 16'h0000, 16'h3ef8};

    // 8 rows per glyph, row 0 in the top byte [63:56]; bit 7 of a row is the
    // leftmost column.
    localparam logic [63:0] GLYPH_BMP [OVL_CNT] = '{
        64'h8142_2418_1824_4281,   // hungry: X shape
        64'hFF81_8181_8181_81FF,   // sick: hollow box
        64'h7E81_A581_99A5_817E,   // sad: face
        64'h00FE_0408_1020_FE00    // tired: Z
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } comp_state_e;

    // Row r of glyph k sits at bits [8*(7-r) +: 8]; for a 3-bit r, 7-r == ~r.
    function automatic logic [7:0] glyph_row(input int k, input logic [2:0] r);
        return GLYPH_BMP[k][{~r, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/glyph_hit.sv
// Purpose : decide whether pixel (x,y) is covered by any enabled glyph and pick its colour.
// Latency : combinational (0 cycles).
// Backpr. : none; pure function of its inputs.
// Ports   : x_i/y_i pixel coordinates, mask_i latched glyph enables,
//           hit_o any glyph covers the pixel, color_o colour of the winning glyph.
module glyph_hit
    import ovl_pkg::*;
#(
    parameter int CW = 7
) (
    input  logic [CW-1:0]      x_i,
    input  logic [CW-1:0]      y_i,
    input  logic [OVL_CNT-1:0] mask_i,
    output logic               hit_o,
    output logic [PIX_W-1:0]   color_o
);

    logic [CW:0] x0;
    logic [CW:0] y0;
    logic [CW:0] dx;
    logic [CW:0] dy;
    logic [7:0]  row;

    always_comb begin
        hit_o   = 1'b0;
        color_o = '0;
        x0      = '0;
        y0      = '0;
        dx      = '0;
        dy      = '0;
        row     = '0;
        // Ascending scan: a later (higher-index) hit overwrites an earlier one,
        // which gives the highest glyph index priority on overlap.
        for (int k = 0; k < OVL_CNT; k++) begin
            x0  = (CW+1)'(GLYPH_X0[k]);
            y0  = (CW+1)'(GLYPH_Y0[k]);
            dx  = {1'b0, x_i} - x0;
            dy  = {1'b0, y_i} - y0;
            row = glyph_row(k, dy[2:0]);
            // In the 8x8 box when coordinate >= origin and the offset fits in 3 bits.
            if (mask_i[k]
                && ({1'b0, x_i} >= x0) && (dx[CW:3] == '0)
                && ({1'b0, y_i} >= y0) && (dy[CW:3] == '0)
                && row[~dx[2:0]]) begin
                hit_o   = 1'b1;
                color_o = GLYPH_COLOR[k];
            end
        end
    end

endmodule

// File: rtl/pixel_overlay_composer.sv
// Purpose : stream one WIDTHxHEIGHT frame from the base ROM with status glyphs composited on top.
// Latency : 2 cycles from rom_addr to pixel_out; pixel 0 three cycles after frame_start is sampled.
// Backpr. : none; one pixel per clk_input_data cycle, consumer must keep up.
// Ports   : clk_input_data, rst (sync, active-low), frame_start, state_mask (latched per frame),
//           rom_addr/rom_data (sync ROM, 1-cycle read), pixel_out/pixel_valid, frame_done (sticky).
module pixel_overlay_composer
    import ovl_pkg::*;
#(
    parameter int WIDTH      = 128,
    parameter int HEIGHT     = 128,
    parameter int PIXEL_SIZE = 16,
    parameter int NUM_OVL    = 4
) (
    input  logic                              clk_input_data,
    input  logic                              rst,
    input  logic                              frame_start,
    input  logic [NUM_OVL-1:0]                state_mask,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   rom_addr,
    input  logic [PIXEL_SIZE-1:0]             rom_data,
    output logic [PIXEL_SIZE-1:0]             pixel_out,
    output logic                              pixel_valid,
    output logic                              frame_done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int CW = (XW > YW) ? XW : YW;
    localparam int AW = $clog2(WIDTH*HEIGHT);

    comp_state_e          state_q;
    logic [NUM_OVL-1:0]   mask_q;
    logic [CW-1:0]        x_q;
    logic [CW-1:0]        y_q;
    logic                 drain_q;
    // S1: coordinates of the address issued last cycle, aligned with rom_data.
    logic                 v1_q;
    logic [CW-1:0]        x1_q;
    logic [CW-1:0]        y1_q;
    // S2: registered outputs.
    logic [PIXEL_SIZE-1:0] pix_q;
    logic                  vld_q;
    logic                  done_q;

    logic                  last_addr;
    logic                  hit;
    logic [PIX_W-1:0]      hit_color;
    logic [PIXEL_SIZE-1:0] pix_d;

    assign last_addr = (x_q == CW'(WIDTH-1)) && (y_q == CW'(HEIGHT-1));
    assign rom_addr  = AW'(32'(y_q) * 32'(WIDTH) + 32'(x_q));

    glyph_hit #(
        .CW (CW)
    ) u_glyph_hit (
        .x_i     (x1_q),
        .y_i     (y1_q),
        .mask_i  (mask_q),
        .hit_o   (hit),
        .color_o (hit_color)
    );

    assign pix_d = hit ? hit_color : rom_data;

    always_ff @(posedge clk_input_data) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            drain_q <= 1'b0;
            v1_q    <= 1'b0;
            x1_q    <= '0;
            y1_q    <= '0;
            pix_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Pipeline advances every cycle; an address is live only in STREAM.
            v1_q  <= (state_q == ST_STREAM);
            x1_q  <= x_q;
            y1_q  <= y_q;
            vld_q <= v1_q;
            // Hold the last pixel once the frame has drained.
            if (v1_q) begin
                pix_q <= pix_d;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (frame_start) begin
                        mask_q  <= state_mask;
                        x_q     <= '0;
                        y_q     <= '0;
                        done_q  <= 1'b0;
                        state_q <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // Counters park on the last address; nothing reads them after STREAM.
                    if (last_addr) begin
                        drain_q <= 1'b0;
                        state_q <= ST_DRAIN;
                    end else if (x_q == CW'(WIDTH-1)) begin
                        x_q <= '0;
                        y_q <= y_q + 1'b1;
                    end else begin
                        x_q <= x_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Two cycles: let the last ROM read and its output register retire.
                    if (drain_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pixel_out   = pix_q;
    assign pixel_valid = vld_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_pixel_overlay_composer.sv
// Purpose : self-checking bench for pixel_overlay_composer with a frame-level reference model.
// Latency : checks pixel 0 at t+3, frame_done at t+N+3, back-to-back restart at done+3.
// Backpr. : none; every valid cycle is captured.
module tb_pixel_overlay_composer;

    localparam int W = 128;
    localparam int H = 128;
    localparam int N = W * H;

    logic        clk_input_data = 1'b0;
    logic        rst            = 1'b0;
    logic        frame_start    = 1'b0;
    logic [3:0]  state_mask     = 4'd0;
    logic [13:0] rom_addr;
    logic [15:0] rom_data;
    logic [15:0] pixel_out;
    logic        pixel_valid;
    logic        frame_done;

    pixel_overlay_composer #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .PIXEL_SIZE (16),
        .NUM_OVL    (4)
    ) dut (
        .clk_input_data (clk_input_data),
        .rst            (rst),
        .frame_start    (frame_start),
        .state_mask     (state_mask),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .pixel_out      (pixel_out),
        .pixel_valid    (pixel_valid),
        .frame_done     (frame_done)
    );

    always #5 clk_input_data = ~clk_input_data;

    // Cycle label: the cycle following the edge that ends cycle t is t+1.
    int cyc = 0;
    always @(posedge clk_input_data) cyc <= cyc + 1;

    // Glyph description: origin, colour, 8 rows (row 0 in the top byte, MSB = left column).
    int          gx0  [4] = '{76, 82, 88, 55};
    int          gy0  [4] = '{57, 53, 58, 44};
    logic [15:0] gcol [4] = '{16'h0000, 16'h4dac, 16'h0000, 16'h3ef8};
    logic [63:0] gbmp [4] = '{64'h8142241818244281, 64'hFF818181818181FF,
                              64'h7E81A58199A5817E, 64'h00FE04081020FE00};

    int          rom_mode = 0;
    logic [15:0] rnd_rom [N];

    function automatic logic [15:0] rom_val(input int a);
        case (rom_mode)
            0:       return a[15:0];
            1:       return 16'hffff;
            default: return rnd_rom[a];
        endcase
    endfunction

    always @(posedge clk_input_data) rom_data <= rom_val(int'(rom_addr));

    // Expected pixel at raster address a: ROM value, painted by each enabled glyph
    // in ascending index order so the highest index ends on top.
    function automatic logic [15:0] model_pix(input int a, input logic [3:0] m);
        int x, y, rx, ry;
        logic [15:0] p;
        x = a % W;
        y = a / W;
        p = rom_val(a);
        for (int k = 0; k < 4; k++) begin
            rx = x - gx0[k];
            ry = y - gy0[k];
            if (m[k] && rx >= 0 && rx < 8 && ry >= 0 && ry < 8 && gbmp[k][63 - (8*ry + rx)])
                p = gcol[k];
        end
        return p;
    endfunction

    int nvec = 0;
    int nbad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Per-frame capture state.
    logic [15:0] cap [N];
    int          ncap;
    int          first_v;
    int          done_cyc;
    bit          gap;
    logic        vld_at_done;
    logic [15:0] pix_at_done;

    task automatic start_frame(input logic [3:0] m, output int t);
        @(negedge clk_input_data);
        frame_start = 1'b1;
        state_mask  = m;
        t           = cyc;
        @(negedge clk_input_data);
        frame_start = 1'b0;
    endtask

    // Capture until frame_done. Optionally raise (and hold) frame_start with a new
    // mask after inj_at pixels, or assert reset after rst_at pixels and stop.
    task automatic collect(input int inj_at, input logic [3:0] inj_mask, input int rst_at);
        logic prev_v;
        ncap        = 0;
        first_v     = -1;
        done_cyc    = -1;
        gap         = 1'b0;
        prev_v      = 1'b0;
        vld_at_done = 1'bx;
        pix_at_done = 'x;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk_input_data);
            if (pixel_valid === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                else if (!prev_v) gap = 1'b1;
                if (ncap < N) cap[ncap] = pixel_out;
                ncap++;
            end
            prev_v = (pixel_valid === 1'b1);
            if (frame_done === 1'b1) begin
                done_cyc    = cyc;
                vld_at_done = pixel_valid;
                pix_at_done = pixel_out;
                break;
            end
            if (ncap == inj_at) begin
                frame_start = 1'b1;
                state_mask  = inj_mask;
            end
            if (ncap == rst_at) begin
                rst = 1'b0;
                break;
            end
        end
    endtask

    function automatic int count_diff(input logic [3:0] m, input int n);
        int bad = 0;
        for (int i = 0; i < n && i < N; i++) begin
            if (cap[i] !== model_pix(i, m)) begin
                if (bad < 4) $display("  diff at addr %0d: got %h want %h", i, cap[i], model_pix(i, m));
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic frame_check(input string nm, input int t, input logic [3:0] m);
        check({nm, " pixel0 cycle"},   first_v,     t + 3);
        check({nm, " valid count"},    ncap,        N);
        check({nm, " valid gap"},      32'(gap),    0);
        check({nm, " done cycle"},     done_cyc,    t + N + 3);
        check({nm, " valid at done"},  32'(vld_at_done), 0);
        check({nm, " last pix held"},  32'(pix_at_done), 32'(model_pix(N-1, m)));
        check({nm, " pixel diffs"},    count_diff(m, ncap), 0);
    endtask

    typedef struct {
        int          fi;
        int          addr;
        logic [15:0] exp;
    } probe_t;

    probe_t probes [11];

    task automatic run_probes(input int fi);
        for (int i = 0; i < 11; i++) begin
            if (probes[i].fi == fi)
                check($sformatf("frame%0d addr %0d", fi, probes[i].addr),
                      32'(cap[probes[i].addr]), 32'(probes[i].exp));
        end
    endtask

    initial begin
        int t, d1;
        logic [3:0] m4, m5;

        // frame 0: mask 0000, ROM = addr; frame 1: mask 1111, ROM = addr;
        // frame 2: mask 0001, ROM = ffff.
        probes[0]  = '{0, 7513, 16'd7513};
        probes[1]  = '{1, 7513, 16'h0000};   // sad over sick at (89,58)
        probes[2]  = '{1, 7506, 16'h4dac};   // sick over hungry at (82,58)
        probes[3]  = '{1, 5816, 16'h3ef8};   // tired at (56,45)
        probes[4]  = '{1, 5687, 16'd5687};   // tired origin, empty row 0
        probes[5]  = '{2, 7372, 16'h0000};   // hungry row0 left column
        probes[6]  = '{2, 7373, 16'hffff};
        probes[7]  = '{2, 7379, 16'h0000};   // hungry row0 right column
        probes[8]  = '{2, 7378, 16'hffff};
        probes[9]  = '{2, 7506, 16'h0000};
        probes[10] = '{2, 7513, 16'hffff};

        for (int i = 0; i < N; i++) rnd_rom[i] = 16'($urandom);

        repeat (3) @(negedge clk_input_data);
        check("reset rom_addr",    32'(rom_addr),    0);
        check("reset pixel_out",   32'(pixel_out),   0);
        check("reset pixel_valid", 32'(pixel_valid), 0);
        check("reset frame_done",  32'(frame_done),  0);
        rst = 1'b1;
        @(negedge clk_input_data);

        // Frame 0, with a mid-frame frame_start + mask change held into the next frame.
        rom_mode = 0;
        start_frame(4'b0000, t);
        check("f0 rom_addr start", 32'(rom_addr), 0);
        collect(5000, 4'b1111, -1);
        frame_check("f0", t, 4'b0000);
        run_probes(0);
        d1 = done_cyc;

        // Frame 1: accepted in DONE on the same cycle frame_done first showed.
        @(negedge clk_input_data);
        frame_start = 1'b0;
        collect(-1, 4'b0000, -1);
        frame_check("f1", d1, 4'b1111);
        run_probes(1);

        rom_mode = 1;
        start_frame(4'b0001, t);
        collect(-1, 4'b0000, -1);
        frame_check("f2", t, 4'b0001);
        run_probes(2);

        // Frame 3: reset after 8000 pixels.
        rom_mode = 2;
        m4 = 4'($urandom_range(0, 15));
        start_frame(m4, t);
        collect(-1, 4'b0000, 8000);
        check("f3 pixel0 cycle", first_v, t + 3);
        check("f3 partial diffs", count_diff(m4, ncap), 0);
        @(negedge clk_input_data);
        check("mid rst rom_addr",    32'(rom_addr),    0);
        check("mid rst pixel_out",   32'(pixel_out),   0);
        check("mid rst pixel_valid", 32'(pixel_valid), 0);
        check("mid rst frame_done",  32'(frame_done),  0);
        rst = 1'b1;
        repeat (4) @(negedge clk_input_data);
        check("idle rom_addr",    32'(rom_addr),    0);
        check("idle pixel_valid", 32'(pixel_valid), 0);

        // Frame 4: clean restart after reset, random mask and ROM.
        m5 = 4'($urandom_range(0, 15));
        start_frame(m5, t);
        collect(-1, 4'b0000, -1);
        frame_check("f4", t, m5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/pixel_overlay_composer.md
# pixel_overlay_composer

Upstream pixel source for the ILI9341 controller. Streams one 128×128 RGB565 frame per request: reads the base sprite from an external synchronous pixel ROM, composites up to four 8×8 status glyphs (hungry, sick, sad, tired) over it, and delivers one pixel per `clk_input_data` cycle. The mood mask is latched per frame, so a status change only takes effect at a frame boundary.

## Interface
- `WIDTH`, 128, frame width in pixels
- `HEIGHT`, 128, frame height in pixels
- `PIXEL_SIZE`, 16, pixel width (RGB565)
- `NUM_OVL`, 4, number of glyph overlays
- `clk_input_data`  in  1  pixel clock (controller data clock)
- `rst`  in  1  reset, synchronous, active-low
- `frame_start`  in  1  request a new frame; sampled only in IDLE/DONE
- `state_mask`  in  NUM_OVL  overlay enables: bit0 hungry, bit1 sick, bit2 sad, bit3 tired; latched at accepted `frame_start`
- `rom_addr`  out  $clog2(WIDTH*HEIGHT)  base-ROM address, y*WIDTH+x
- `rom_data`  in  PIXEL_SIZE  base-ROM data, valid 1 cycle after `rom_addr`
- `pixel_out`  out  PIXEL_SIZE  composited pixel
- `pixel_valid`  out  1  `pixel_out` holds a frame pixel this cycle
- `frame_done`  out  1  frame fully emitted; held until the next accepted `frame_start`

## Operation
- FSM states: IDLE (after reset), STREAM (issuing addresses), DRAIN (pipeline emptying), DONE.
- IDLE/DONE with `frame_start`=1: latch `state_mask`, clear x/y, go to STREAM, clear `frame_done`.
- STREAM: each cycle issue `rom_addr`=y*WIDTH+x, then advance x. When x reaches WIDTH-1, wrap x to 0 and increment y. After address WIDTH*HEIGHT-1, go to DRAIN.
- DRAIN: 2 cycles, then go to DONE and set `frame_done`=1.
- Pipeline, 3 stages: S0 address/coords → S1 ROM data plus delayed x,y → S2 registered output.
- Compositing in S1: glyph k hits when `mask_latched[k]`=1, x0_k ≤ x < x0_k+8, y0_k ≤ y < y0_k+8, and bitmap_k[y-y0_k][7-(x-x0_k)]=1. Bit 7 is the leftmost column.
- On a hit, the pixel is COLOR_k; otherwise it is `rom_data`. On overlapping hits the highest index k wins.
- All coordinate comparisons are unsigned. Glyph extents never exceed the frame.
- `frame_start` in STREAM or DRAIN is ignored and has no queued effect. `state_mask` changes mid-frame are ignored.
- Reset (`rst`=0 on an edge) from any state: go to IDLE, clear all outputs and counters, clear the latched mask. A partially sent frame is abandoned.

## Timing
- Reset values: `rom_addr`=0, `pixel_out`=0, `pixel_valid`=0, `frame_done`=0, FSM=IDLE.
- `frame_start` sampled at edge t:
  - `rom_addr`=0 from t+1.
  - Pixel 0 on `pixel_out` with `pixel_valid`=1 from t+3.
  - `pixel_valid` stays high for exactly N=WIDTH*HEIGHT contiguous cycles, t+3..t+N+2. There is no backpressure; the consumer takes one pixel per cycle.
  - From t+N+3: `pixel_valid`=0, `frame_done`=1, `pixel_out` holds the last pixel.
- A new `frame_start` sampled in DONE at edge u: `frame_done` falls at u+1 and pixel 0 appears at u+3. The minimum frame-to-frame period is N+3 cycles.
- Latency is fixed at 2 cycles from address to output.

## Structure
- Shared package `ovl_pkg` holds:
  - Index constants OVL_HUNGRY=0, OVL_SICK=1, OVL_SAD=2, OVL_TIRED=3.
  - Per-glyph origin (x0,y0): hungry (76,57), sick (82,53), sad (88,58), tired (55,44).
  - Per-glyph colour: 16'h0000, 16'h4dac, 16'h0000, 16'h3ef8.
  - Per-glyph 8×8 bitmaps (8 bytes each).
- One sub-module, `glyph_hit`: combinational; inputs x, y, latched mask; outputs hit flag and selected colour with priority resolution.
- FSM, counters and pipeline registers live in the top block.

## Test plan
- mask=0000, ROM[a]=a[15:0], one frame → 16384 valid pixels with `pixel_out`==a in order; `frame_done` rises at t+16387.
- mask=0001, hungry row0 bitmap=8'b1000_0001, ROM all 16'hffff → pixels at addr 7372 and 7379 = 16'h0000; addr 7373 = 16'hffff.
- mask=1111, with sick and sad glyphs overlapping at one pixel and both bits set → the sad colour (16'h0000) wins over sick (16'h4dac).
- `frame_start` pulsed at pixel 5000 of a running frame, and `state_mask` changed at the same time → no restart, 16384 contiguous valid pixels, overlays use the old mask.
- `rst`=0 at pixel 8000 → next cycle all outputs 0 and FSM in IDLE; a following `frame_start` restarts cleanly from addr 0.
- Back-to-back: `frame_start` held high → the second frame's pixel 0 appears exactly 3 cycles after `frame_done` first rises.
